// File: rtl/exec_unit_seq_if.sv
// Instruction handshake, completion status and debug read port of exec_unit_seq.
// The testbench or upstream pipeline drives the master side.
interface exec_unit_seq_if #(
    parameter int DATA_W = 16
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              done;
    logic              err;
    logic [3:0]        flags;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] sgpr;

    modport master (
        output instr_valid, instr, rd_addr,
        input  instr_ready, done, err, flags, rd_data, sgpr
    );

    modport slave (
        input  instr_valid, instr, rd_addr,
        output instr_ready, done, err, flags, rd_data, sgpr
    );
endinterface

// File: rtl/exec_unit_seq.sv
// Clocked execute unit: GPR file, SGPR and registered flags {sign, zero, overflow, carry}.
// Single-cycle ALU ops complete on the accept edge; mul is an iterative shift-add over DATA_W cycles.
module exec_unit_seq #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 32
) (
    input logic            clk,
    input logic            sys_rst,
    exec_unit_seq_if.slave bus
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, MUL} state_e;

    typedef enum logic [4:0] {
        OP_MOVSGPR = 5'd0,  OP_MOV  = 5'd1,  OP_ADD  = 5'd2,  OP_SUB  = 5'd3,
        OP_MUL     = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_XOR  = 5'd7,
        OP_XNOR    = 5'd8,  OP_NAND = 5'd9,  OP_NOR  = 5'd10, OP_NOT  = 5'd11
    } op_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   gpr_q [NUM_REGS];
    logic [DATA_W-1:0]   sgpr_q, sgpr_d;
    logic [3:0]          flags_q, flags_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [2*DATA_W-1:0] mulA_q, mulA_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   mulB_q, mulB_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    mulRd_q, mulRd_d;

    logic                wrEn;
    logic [IDX_W-1:0]    wrIdx;
    logic [DATA_W-1:0]   wrData;

    logic [4:0]          opField, rdst, rsrc1, rsrc2;
    logic                immMode, accept, opSupported, rangeErr;
    logic [DATA_W-1:0]   opA, opB, aluRes;
    logic                aluCarry, aluOv;
    logic [DATA_W:0]     sumW, diffW;
    logic [2*DATA_W-1:0] accNext;

    assign opField = bus.instr[31:27];
    assign rdst    = bus.instr[26:22];
    assign rsrc1   = bus.instr[21:17];
    assign immMode = bus.instr[16];
    assign rsrc2   = bus.instr[15:11];

    assign accept      = bus.instr_valid && (state_q == IDLE);
    assign opSupported = (opField <= OP_NOT);
    // rsrc2 bits are part of the immediate when imm_mode is set, so only range-check them as a register index
    assign rangeErr    = (int'(rdst) >= NUM_REGS) || (int'(rsrc1) >= NUM_REGS) ||
                         (!immMode && (int'(rsrc2) >= NUM_REGS));

    assign opA = (int'(rsrc1) < NUM_REGS) ? gpr_q[rsrc1[IDX_W-1:0]] : '0;
    assign opB = immMode ? DATA_W'(bus.instr[15:0]) :
                 ((int'(rsrc2) < NUM_REGS) ? gpr_q[rsrc2[IDX_W-1:0]] : '0);

    assign sumW    = {1'b0, opA} + {1'b0, opB};
    assign diffW   = {1'b0, opA} - {1'b0, opB};
    assign accNext = acc_q + (mulB_q[0] ? mulA_q : '0);

    always_comb begin
        aluRes   = '0;
        aluCarry = 1'b0;
        aluOv    = 1'b0;
        case (opField)
            OP_MOVSGPR: aluRes = sgpr_q;
            OP_MOV:     aluRes = opB;
            OP_ADD: begin
                aluRes   = sumW[DATA_W-1:0];
                aluCarry = sumW[DATA_W];
                aluOv    = (opA[DATA_W-1] == opB[DATA_W-1]) && (sumW[DATA_W-1] != opA[DATA_W-1]);
            end
            OP_SUB: begin
                aluRes   = diffW[DATA_W-1:0];
                aluCarry = diffW[DATA_W];
                aluOv    = (opA[DATA_W-1] != opB[DATA_W-1]) && (diffW[DATA_W-1] != opA[DATA_W-1]);
            end
            OP_AND:     aluRes = opA & opB;
            OP_OR:      aluRes = opA | opB;
            OP_XOR:     aluRes = opA ^ opB;
            OP_XNOR:    aluRes = ~(opA ^ opB);
            OP_NAND:    aluRes = ~(opA & opB);
            OP_NOR:     aluRes = ~(opA | opB);
            OP_NOT:     aluRes = ~opA;
            default:    aluRes = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sgpr_d  = sgpr_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mulA_d  = mulA_q;
        mulB_d  = mulB_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mulRd_d = mulRd_q;
        wrEn    = 1'b0;
        wrIdx   = rdst[IDX_W-1:0];
        wrData  = aluRes;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!opSupported || rangeErr) begin
                        flags_d = '0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (opField == OP_MUL) begin
                        state_d = MUL;
                        mulA_d  = {{DATA_W{1'b0}}, opA};
                        mulB_d  = opB;
                        acc_d   = '0;
                        cnt_d   = '0;
                        mulRd_d = rdst[IDX_W-1:0];
                    end else begin
                        wrEn    = 1'b1;
                        flags_d = {aluRes[DATA_W-1], (aluRes == '0), aluOv, aluCarry};
                        done_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                // The last partial product is folded straight into the writeback so done lands DATA_W edges after accept
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    wrEn    = 1'b1;
                    wrIdx   = mulRd_q;
                    wrData  = accNext[DATA_W-1:0];
                    sgpr_d  = accNext[2*DATA_W-1:DATA_W];
                    flags_d = {accNext[2*DATA_W-1], (accNext == '0),
                               (accNext[2*DATA_W-1:DATA_W] != '0), 1'b0};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    acc_d  = accNext;
                    mulA_d = mulA_q << 1;
                    mulB_d = mulB_q >> 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
            state_q <= IDLE;
            sgpr_q  <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mulA_q  <= '0;
            mulB_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mulRd_q <= '0;
        end else begin
            if (wrEn) gpr_q[wrIdx] <= wrData;
            state_q <= state_d;
            sgpr_q  <= sgpr_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mulA_q  <= mulA_d;
            mulB_q  <= mulB_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mulRd_q <= mulRd_d;
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.flags       = flags_q;
    assign bus.sgpr        = sgpr_q;
    assign bus.rd_data     = (int'(bus.rd_addr) < NUM_REGS) ? gpr_q[bus.rd_addr[IDX_W-1:0]] : '0;
endmodule

// File: tb/tb_exec_unit_seq.sv
// Scoreboard bench for exec_unit_seq: a 32-register and an 8-register instance share clock and reset.
module tb_exec_unit_seq;
    localparam int DATA_W = 16;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_AND     = 5'd5;
    localparam logic [4:0] OP_OR      = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;
    localparam logic [4:0] OP_BAD     = 5'd31;

    typedef struct {
        logic [4:0] resp;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t expQ8[$];

    exec_unit_seq_if #(.DATA_W(DATA_W)) bus ();
    exec_unit_seq_if #(.DATA_W(DATA_W)) bus8 ();

    exec_unit_seq #(.DATA_W(DATA_W), .NUM_REGS(32)) dut  (.clk(clk), .sys_rst(sys_rst), .bus(bus));
    exec_unit_seq #(.DATA_W(DATA_W), .NUM_REGS(8))  dut8 (.clk(clk), .sys_rst(sys_rst), .bus(bus8));

    always #5 clk = ~clk;

    function automatic logic [31:0] immI(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [15:0] val);
        return {op, rd, rs1, 1'b1, val};
    endfunction

    function automatic logic [31:0] regI(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one instruction; resp = {err, sign, zero, overflow, carry} expected at its done pulse
    task automatic applyStimulus(input int sel, input logic [31:0] word, input logic [4:0] resp,
                                 input bit track, input string name);
        int waitCnt = 0;
        if (sel == 0) begin
            while (bus.instr_ready !== 1'b1 && waitCnt < 50) begin
                @(posedge clk); #1; waitCnt++;
            end
            if (waitCnt >= 50) checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
            bus.instr       = word;
            bus.instr_valid = 1'b1;
            if (track) expQ.push_back('{resp: resp, name: name});
            @(posedge clk); #1;
            bus.instr_valid = 1'b0;
            bus.instr       = $urandom;
        end else begin
            while (bus8.instr_ready !== 1'b1 && waitCnt < 50) begin
                @(posedge clk); #1; waitCnt++;
            end
            if (waitCnt >= 50) checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
            bus8.instr       = word;
            bus8.instr_valid = 1'b1;
            if (track) expQ8.push_back('{resp: resp, name: name});
            @(posedge clk); #1;
            bus8.instr_valid = 1'b0;
            bus8.instr       = $urandom;
        end
    endtask

    task automatic readReg(input int sel, input logic [4:0] addr, input logic [15:0] exp,
                           input string name);
        if (sel == 0) begin
            bus.rd_addr = addr; #1;
            checkOutput(name, {16'b0, bus.rd_data}, {16'b0, exp});
        end else begin
            bus8.rd_addr = addr; #1;
            checkOutput(name, {16'b0, bus8.rd_data}, {16'b0, exp});
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || expQ8.size() != 0) && n < 60) begin
            @(negedge clk); n++;
        end
        checkOutput("scoreboard drain", expQ.size() + expQ8.size(), 32'd0);
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (expQ.size() == 0) checkOutput("unexpected done", 32'd1, 32'd0);
            else begin
                e = expQ.pop_front();
                checkOutput(e.name, {27'b0, bus.err, bus.flags}, {27'b0, e.resp});
            end
        end else if (bus.err === 1'b1) checkOutput("err without done", 32'd1, 32'd0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus8.done === 1'b1) begin
            if (expQ8.size() == 0) checkOutput("unexpected done r8", 32'd1, 32'd0);
            else begin
                e = expQ8.pop_front();
                checkOutput(e.name, {27'b0, bus8.err, bus8.flags}, {27'b0, e.resp});
            end
        end else if (bus8.err === 1'b1) checkOutput("err without done r8", 32'd1, 32'd0);
    end

    initial begin
        int lat;
        int readyLow;
        bus.instr_valid  = 1'b0; bus.instr  = '0; bus.rd_addr  = '0;
        bus8.instr_valid = 1'b0; bus8.instr = '0; bus8.rd_addr = '0;
        sys_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ready", {31'b0, bus.instr_ready}, 32'd1);
        checkOutput("reset flags", {28'b0, bus.flags}, 32'd0);
        checkOutput("reset sgpr", {16'b0, bus.sgpr}, 32'd0);
        checkOutput("reset done", {31'b0, bus.done}, 32'd0);
        sys_rst = 1'b0;

        applyStimulus(0, immI(OP_MOV, 5'd1, 5'd0, 16'h00FF), 5'b0_0000, 1, "mov r1");
        applyStimulus(0, immI(OP_MOV, 5'd2, 5'd0, 16'h7FFF), 5'b0_0000, 1, "mov r2");
        applyStimulus(0, immI(OP_ADD, 5'd3, 5'd2, 16'h0001), 5'b0_1010, 1, "add overflow");
        applyStimulus(0, immI(OP_MOV, 5'd4, 5'd0, 16'hFFFF), 5'b0_1000, 1, "mov r4");
        applyStimulus(0, immI(OP_ADD, 5'd5, 5'd4, 16'h0001), 5'b0_0101, 1, "add carry");
        applyStimulus(0, immI(OP_MOV, 5'd6, 5'd0, 16'h0003), 5'b0_0000, 1, "mov r6");
        applyStimulus(0, immI(OP_SUB, 5'd7, 5'd6, 16'h0005), 5'b0_1001, 1, "sub borrow");
        applyStimulus(0, immI(OP_MOV, 5'd8, 5'd0, 16'h1234), 5'b0_0000, 1, "mov r8");
        applyStimulus(0, immI(OP_MOV, 5'd9, 5'd0, 16'h5678), 5'b0_0000, 1, "mov r9");

        applyStimulus(0, regI(OP_MUL, 5'd10, 5'd8, 5'd9), 5'b0_0010, 1, "mul");
        lat = 0; readyLow = 0;
        while (lat < 40) begin
            @(negedge clk); lat++;
            if (bus.instr_ready !== 1'b1) readyLow++;
            if (bus.done === 1'b1) break;
        end
        checkOutput("mul latency", lat, 32'd17);
        checkOutput("mul ready low cycles", readyLow, 32'd16);
        checkOutput("mul sgpr", {16'b0, bus.sgpr}, 32'h0626);

        applyStimulus(0, immI(OP_MOVSGPR, 5'd11, 5'd0, 16'h0000), 5'b0_0000, 1, "movsgpr");
        applyStimulus(0, regI(OP_AND,  5'd13, 5'd1, 5'd2),        5'b0_0000, 1, "and");
        applyStimulus(0, immI(OP_OR,   5'd14, 5'd1, 16'hF000),    5'b0_1000, 1, "or");
        applyStimulus(0, regI(OP_XOR,  5'd15, 5'd1, 5'd1),        5'b0_0100, 1, "xor");
        applyStimulus(0, immI(OP_XNOR, 5'd16, 5'd1, 16'h00FF),    5'b0_1000, 1, "xnor");
        applyStimulus(0, regI(OP_NAND, 5'd17, 5'd2, 5'd2),        5'b0_1000, 1, "nand");
        applyStimulus(0, immI(OP_NOR,  5'd18, 5'd1, 16'hFF00),    5'b0_0100, 1, "nor");
        applyStimulus(0, regI(OP_NOT,  5'd19, 5'd1, 5'd0),        5'b0_1000, 1, "not");
        applyStimulus(0, immI(OP_ADD,  5'd1,  5'd1, 16'h0001),    5'b0_0000, 1, "add rd=rs1");
        applyStimulus(0, regI(OP_SUB,  5'd20, 5'd6, 5'd6),        5'b0_0100, 1, "sub zero");
        applyStimulus(0, immI(OP_MOV,  5'd12, 5'd0, 16'hAAAA),    5'b0_1000, 1, "mov r12");
        applyStimulus(0, immI(OP_BAD,  5'd12, 5'd1, 16'h1111),    5'b1_0000, 1, "unsupported op");
        waitDrain();

        readReg(0, 5'd1,  16'h0100, "r1");
        readReg(0, 5'd3,  16'h8000, "r3");
        readReg(0, 5'd5,  16'h0000, "r5");
        readReg(0, 5'd7,  16'hFFFE, "r7");
        readReg(0, 5'd10, 16'h0060, "r10 mul low");
        readReg(0, 5'd11, 16'h0626, "r11 movsgpr");
        readReg(0, 5'd12, 16'hAAAA, "r12 kept");
        readReg(0, 5'd14, 16'hF0FF, "r14 or");
        readReg(0, 5'd16, 16'hFFFF, "r16 xnor");
        readReg(0, 5'd17, 16'h8000, "r17 nand");
        readReg(0, 5'd19, 16'hFF00, "r19 not");

        applyStimulus(1, immI(OP_MOV, 5'd7, 5'd0, 16'h0005), 5'b0_0000, 1, "n8 mov r7");
        applyStimulus(1, immI(OP_ADD, 5'd9, 5'd1, 16'h0001), 5'b1_0000, 1, "n8 rdst range");
        applyStimulus(1, immI(OP_ADD, 5'd3, 5'd10, 16'h0001), 5'b1_0000, 1, "n8 rsrc1 range");
        applyStimulus(1, regI(OP_ADD, 5'd2, 5'd1, 5'd12),     5'b1_0000, 1, "n8 rsrc2 range");
        applyStimulus(1, immI(OP_ADD, 5'd6, 5'd7, 16'h0002), 5'b0_0000, 1, "n8 add");
        waitDrain();
        readReg(1, 5'd7, 16'h0005, "n8 r7");
        readReg(1, 5'd6, 16'h0007, "n8 r6");
        readReg(1, 5'd3, 16'h0000, "n8 r3 untouched");
        readReg(1, 5'd9, 16'h0000, "n8 rd_addr out of range");

        // Abort a multiply with reset part-way through; no done may follow
        applyStimulus(0, regI(OP_MUL, 5'd10, 5'd8, 5'd9), 5'b0_0000, 0, "mul aborted");
        repeat (4) @(posedge clk);
        #1 sys_rst = 1'b1;
        @(posedge clk);
        #1 sys_rst = 1'b0;
        checkOutput("abort ready", {31'b0, bus.instr_ready}, 32'd1);
        checkOutput("abort flags", {28'b0, bus.flags}, 32'd0);
        checkOutput("abort sgpr", {16'b0, bus.sgpr}, 32'd0);
        readReg(0, 5'd1,  16'h0000, "abort r1");
        readReg(0, 5'd10, 16'h0000, "abort r10");
        readReg(0, 5'd12, 16'h0000, "abort r12");
        repeat (25) @(negedge clk);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
